// File: rtl/frank_loader_pkg.sv
// Shared definitions for the FRANK6000 program loader.
//   state_t        - loader FSM states
//   BYTES_PER_WORD - host bytes per instruction word (high byte first)
//   ctrl_t         - CPU-facing control bundle decoded from the state
package frank_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WRITE,
    PRIME,
    RUN,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 2;

  typedef struct packed {
    logic on;
    logic control_en;
    logic cpu_rst;
    logic busy;
  } ctrl_t;

  // CPU control levels are a pure function of the loader state, so they
  // change only on state-register edges.
  function automatic ctrl_t ctrl_for_state(input state_t s);
    ctrl_t c;
    c.on         = (s == PRIME) || (s == RUN);
    c.control_en = (s == RUN);
    c.cpu_rst    = (s != RUN);
    c.busy       = (s != IDLE) && (s != DONE);
    return c;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte-stream handshake into the program loader.
//   i_byte        - host data byte
//   i_byte_valid  - i_byte is valid
//   o_byte_ready  - loader accepts a byte this cycle
// A byte moves when valid and ready are both high on a clock edge.
// master = host side, slave = loader side.
interface program_loader_if;

  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_byte_ready;

  modport master (
    output i_byte,
    output i_byte_valid,
    input  o_byte_ready
  );

  modport slave (
    input  i_byte,
    input  i_byte_valid,
    output o_byte_ready
  );

endinterface

// File: rtl/loader_byte_assembler.sv
// Byte handshake and instruction-word assembly for the program loader.
//   clk, srst   - clock, synchronous active-high reset
//   state       - current loader state (gates ready and byte capture)
//   bus         - host byte stream (slave side)
//   byte_xfer   - a byte is transferred on this edge
//   word        - assembled instruction word (held between writes)
//   word_valid  - one-cycle pulse, high in the cycle after the low byte
module loader_byte_assembler
  import frank_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        srst,
  input  state_t                      state,
  program_loader_if.slave             bus,
  output logic                        byte_xfer,
  output logic [BYTES_PER_WORD*8-1:0] word,
  output logic                        word_valid
);

  localparam int WORD_W = BYTES_PER_WORD * 8;

  logic              ready;
  logic [WORD_W-1:0] word_reg;
  logic              word_valid_reg;

  assign ready            = (state == LEN) || (state == HI) || (state == LO);
  assign bus.o_byte_ready = ready;
  assign byte_xfer        = bus.i_byte_valid && ready;

  // High byte lands as soon as it arrives; the low byte completes the word
  // and raises word_valid for exactly the following (WRITE) cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (byte_xfer && (state == HI)) begin
        word_reg[WORD_W-1 -: 8] <= bus.i_byte;
      end
      if (byte_xfer && (state == LO)) begin
        word_reg[7:0]  <= bus.i_byte;
        word_valid_reg <= 1'b1;
      end
    end
  end

  assign word       = word_reg;
  assign word_valid = word_valid_reg;

endmodule

// File: rtl/program_loader.sv
// FRANK6000 boot/supervisor: loads a length-prefixed byte stream into CPU
// instruction memory, primes fetch, runs the CPU until loopf or timeout and
// captures WREG and the run-cycle count.
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_start           - begin a load (only from IDLE or DONE)
//   byte_if           - host byte stream (i_byte / i_byte_valid / o_byte_ready)
//   o_instr_addr/o_instr/o_instr_we - CPU instruction load port
//   o_ON/o_control_en/o_cpu_rst     - CPU run control
//   i_loopf, i_WREG   - CPU halt-loop flag and working register
//   o_busy/o_done/o_timeout/o_result/o_cycles - run status
module program_loader
  import frank_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  program_loader_if.slave          byte_if,
  output logic [ADDR_WIDTH-1:0]    o_instr_addr,
  output logic [DATA_WIDTH-1:0]    o_instr,
  output logic                     o_instr_we,
  output logic                     o_ON,
  output logic                     o_control_en,
  output logic                     o_cpu_rst,
  input  logic                     i_loopf,
  input  logic [7:0]               i_WREG,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic [7:0]               o_result,
  output logic [TIMEOUT_WIDTH-1:0] o_cycles
);

  state_t                   state_reg;
  ctrl_t                    ctrl;
  logic                     byte_xfer;
  logic                     word_valid;
  logic [DATA_WIDTH-1:0]    word;
  logic [ADDR_WIDTH-1:0]    len_reg;
  logic [ADDR_WIDTH-1:0]    wcnt_reg;
  logic [ADDR_WIDTH-1:0]    wcnt_inc;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic                     done_reg;
  logic                     timeout_reg;
  logic [7:0]               result_reg;
  logic [TIMEOUT_WIDTH-1:0] cycles_reg;

  loader_byte_assembler u_asm (
    .clk        (i_clk),
    .srst       (i_rst),
    .state      (state_reg),
    .bus        (byte_if),
    .byte_xfer  (byte_xfer),
    .word       (word),
    .word_valid (word_valid)
  );

  // Wraps naturally, so a length byte of 0 means a full 2**ADDR_WIDTH words.
  assign wcnt_inc = wcnt_reg + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      wcnt_reg    <= '0;
      addr_reg    <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      result_reg  <= '0;
      cycles_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) state_reg <= LEN;
        end
        LEN: begin
          if (byte_xfer) begin
            len_reg   <= ADDR_WIDTH'(byte_if.i_byte);
            wcnt_reg  <= '0;
            state_reg <= HI;
          end
        end
        HI: begin
          if (byte_xfer) state_reg <= LO;
        end
        LO: begin
          if (byte_xfer) begin
            // Address is set alongside the low byte so it is valid with we.
            addr_reg  <= wcnt_reg;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          wcnt_reg <= wcnt_inc;
          if (wcnt_inc == len_reg) begin
            cycles_reg <= '0;
            state_reg  <= PRIME;
          end else begin
            state_reg <= HI;
          end
        end
        PRIME: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (i_loopf) begin
            result_reg  <= i_WREG;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end else if (&cycles_reg) begin
            result_reg  <= i_WREG;
            timeout_reg <= 1'b1;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end else begin
            cycles_reg <= cycles_reg + 1'b1;
          end
        end
        DONE: begin
          if (i_start) begin
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            state_reg   <= LEN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ctrl = ctrl_for_state(state_reg);

  assign o_ON         = ctrl.on;
  assign o_control_en = ctrl.control_en;
  assign o_cpu_rst    = ctrl.cpu_rst;
  assign o_busy       = ctrl.busy;
  assign o_instr_we   = word_valid;
  assign o_instr      = word;
  assign o_instr_addr = addr_reg;
  assign o_done       = done_reg;
  assign o_timeout    = timeout_reg;
  assign o_result     = result_reg;
  assign o_cycles     = cycles_reg;

endmodule
